// File: rtl/multiplier_if.sv
// Operand/result bundle for the 8x8 pipelined multiplier.
// Valid-only stream with no ready: a/b are sampled on every rising edge where
// in_valid=1, and the product leaves two edges later with out_valid=1.
interface multiplier_if;
    logic [7:0]  a;
    logic [7:0]  b;
    logic        in_valid;
    logic [15:0] y;
    logic        out_valid;

    modport master (
        output a,
        output b,
        output in_valid,
        input  y,
        input  out_valid
    );

    modport slave (
        input  a,
        input  b,
        input  in_valid,
        output y,
        output out_valid
    );
endinterface

// File: rtl/multiplier.sv
// Unsigned 8x8 -> 16 multiplier: carry-save tree to two rows, registered,
// then one carry-propagate add into the registered product.
module multiplier (
    input  logic          clk,
    input  logic          rst,
    multiplier_if.slave   bus
);
    typedef logic [15:0] row_t;

    function automatic row_t csa_sum(input row_t x, input row_t y, input row_t z);
        return x ^ y ^ z;
    endfunction

    // Majority bits shift up one column; the bit leaving column 15 is always
    // zero for any product of two bytes, so dropping it is exact.
    function automatic row_t csa_carry(input row_t x, input row_t y, input row_t z);
        row_t maj;
        maj = (x & y) | (x & z) | (y & z);
        return {maj[14:0], 1'b0};
    endfunction

    row_t pp [8];
    row_t s_l1a, c_l1a, s_l1b, c_l1b;
    row_t s_l2a, c_l2a, s_l2b, c_l2b;
    row_t s_l3, c_l3;
    row_t sum_row, carry_row;

    always_comb begin
        for (int i = 0; i < 8; i++) begin
            pp[i] = bus.b[i] ? (row_t'(bus.a) << i) : '0;
        end
    end

    // 8 rows -> 6 -> 4 -> 3 -> 2
    assign s_l1a     = csa_sum  (pp[0], pp[1], pp[2]);
    assign c_l1a     = csa_carry(pp[0], pp[1], pp[2]);
    assign s_l1b     = csa_sum  (pp[3], pp[4], pp[5]);
    assign c_l1b     = csa_carry(pp[3], pp[4], pp[5]);
    assign s_l2a     = csa_sum  (s_l1a, c_l1a, s_l1b);
    assign c_l2a     = csa_carry(s_l1a, c_l1a, s_l1b);
    assign s_l2b     = csa_sum  (c_l1b, pp[6], pp[7]);
    assign c_l2b     = csa_carry(c_l1b, pp[6], pp[7]);
    assign s_l3      = csa_sum  (s_l2a, c_l2a, s_l2b);
    assign c_l3      = csa_carry(s_l2a, c_l2a, s_l2b);
    assign sum_row   = csa_sum  (s_l3, c_l3, c_l2b);
    assign carry_row = csa_carry(s_l3, c_l3, c_l2b);

    row_t s1_q, c1_q, y_q;
    logic v1_q, out_valid_q;

    // Stage registers only load on valid so idle operands never reach y.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_q        <= '0;
            c1_q        <= '0;
            v1_q        <= 1'b0;
            y_q         <= '0;
            out_valid_q <= 1'b0;
        end else begin
            v1_q        <= bus.in_valid;
            out_valid_q <= v1_q;
            if (bus.in_valid) begin
                s1_q <= sum_row;
                c1_q <= carry_row;
            end
            if (v1_q) begin
                y_q <= s1_q + c1_q;
            end
        end
    end

    assign bus.y         = y_q;
    assign bus.out_valid = out_valid_q;
endmodule

// File: tb/tb_multiplier.sv
// Directed and exhaustive checks of the pipelined 8x8 multiplier.
module tb_multiplier;
    logic clk = 1'b0;
    logic rst = 1'b0;
    multiplier_if bus ();

    multiplier dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;
    logic [15:0] exp_q[$];

    task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Called at a negedge: apply inputs, cross one rising edge, return at the next negedge.
    task automatic step(input logic [7:0] a, input logic [7:0] b, input logic v);
        bus.a        = a;
        bus.b        = b;
        bus.in_valid = v;
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic idle();
        step(8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)), 1'b0);
    endtask

    initial begin
        bus.a        = 8'($urandom_range(0, 255));
        bus.b        = 8'($urandom_range(0, 255));
        bus.in_valid = 1'b1;

        // Reset asserted before the first edge, checked asynchronously.
        #1 rst = 1'b1;
        #1;
        check("rst_async_y", bus.y, 16'h0000);
        check("rst_async_ov", 16'(bus.out_valid), 16'h0000);
        @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            step(8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)), 1'b1);
            check("rst_hold_y", bus.y, 16'h0000);
            check("rst_hold_ov", 16'(bus.out_valid), 16'h0000);
        end
        rst = 1'b0;
        idle();
        idle();

        // Maximum operands
        step(8'hFF, 8'hFF, 1'b1);
        check("max_lat_ov", 16'(bus.out_valid), 16'h0000);
        idle();
        check("max_y", bus.y, 16'hFE01);
        check("max_ov", 16'(bus.out_valid), 16'h0001);
        idle();
        check("max_ov_drop", 16'(bus.out_valid), 16'h0000);
        check("max_y_hold", bus.y, 16'hFE01);

        // Back-to-back identity/zero vectors
        step(8'h00, 8'h5A, 1'b1);
        step(8'h01, 8'h01, 1'b1);
        check("b2b0_y", bus.y, 16'h0000);
        check("b2b0_ov", 16'(bus.out_valid), 16'h0001);
        step(8'h80, 8'h02, 1'b1);
        check("b2b1_y", bus.y, 16'h0001);
        check("b2b1_ov", 16'(bus.out_valid), 16'h0001);
        step(8'hAA, 8'h55, 1'b1);
        check("b2b2_y", bus.y, 16'h0100);
        check("b2b2_ov", 16'(bus.out_valid), 16'h0001);
        idle();
        check("b2b3_y", bus.y, 16'h3872);
        check("b2b3_ov", 16'(bus.out_valid), 16'h0001);
        idle();
        check("b2b_end_ov", 16'(bus.out_valid), 16'h0000);

        // Gap in the valid stream
        step(8'd3, 8'd7, 1'b1);
        idle();
        check("gap0_y", bus.y, 16'd21);
        check("gap0_ov", 16'(bus.out_valid), 16'h0001);
        step(8'd12, 8'd12, 1'b1);
        check("gap_hole_y", bus.y, 16'd21);
        check("gap_hole_ov", 16'(bus.out_valid), 16'h0000);
        idle();
        check("gap1_y", bus.y, 16'd144);
        check("gap1_ov", 16'(bus.out_valid), 16'h0001);

        // Reset between the two pipeline edges
        step(8'hFF, 8'h02, 1'b1);
        bus.in_valid = 1'b0;
        rst = 1'b1;
        #1;
        check("mid_async_y", bus.y, 16'h0000);
        check("mid_async_ov", 16'(bus.out_valid), 16'h0000);
        @(negedge clk);
        idle();
        check("mid_rst_y", bus.y, 16'h0000);
        check("mid_rst_ov", 16'(bus.out_valid), 16'h0000);
        rst = 1'b0;
        for (int i = 0; i < 2; i++) begin
            idle();
            check("mid_after_y", bus.y, 16'h0000);
            check("mid_after_ov", 16'(bus.out_valid), 16'h0000);
        end
        step(8'd5, 8'd6, 1'b1);
        check("mid_fresh_lat_ov", 16'(bus.out_valid), 16'h0000);
        idle();
        check("mid_fresh_y", bus.y, 16'd30);
        check("mid_fresh_ov", 16'(bus.out_valid), 16'h0001);
        idle();

        // Exhaustive back-to-back stream
        for (int i = 0; i <= 65536; i++) begin
            if (i < 65536) begin
                logic [15:0] idx;
                logic [7:0]  ea, eb;
                idx = 16'(i);
                ea  = idx[15:8];
                eb  = idx[7:0];
                exp_q.push_back(16'(ea) * 16'(eb));
                step(ea, eb, 1'b1);
            end else begin
                idle();
            end
            if (i >= 1) begin
                check("exh_ov", 16'(bus.out_valid), 16'h0001);
                if (exp_q.size() == 0) begin
                    check("exh_queue_empty", 16'h0001, 16'h0000);
                end else begin
                    check("exh_y", bus.y, exp_q.pop_front());
                end
            end
        end
        idle();
        check("exh_end_ov", 16'(bus.out_valid), 16'h0000);
        check("exh_queue_left", 16'(exp_q.size()), 16'h0000);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/multiplier.md
Name:
multiplier

Overview:
- Unsigned 8x8 -> 16-bit multiplier, pipelined, one result per clock.
- Partial-product rows are reduced with a tree of ternary (3:2 carry-save) compressors to two rows; one final carry-propagate add follows.
- Used as a shared arithmetic leaf cell wherever an exact 16-bit product of two bytes is needed.

Parameters:
- None. Widths are fixed: operands 8 bits, product 16 bits.

Ports:
- clk  input  1  rising-edge clock, sole clock domain
- rst  input  1  asynchronous, active-high reset
- a  input  8  multiplicand, unsigned
- b  input  8  multiplier, unsigned
- in_valid  input  1  a/b qualify a new operation this cycle
- y  output  16  product a*b, unsigned, registered
- out_valid  output  1  y holds a new product this cycle

Behaviour:
- Clocking/reset: single clock clk; reset rst is asynchronous and active-high.
- While rst=1, and immediately on its assertion:
  - all pipeline registers clear;
  - y=16'h0000 and out_valid=0.
- Stage 0 (combinational, before edge k):
  - form 8 partial products pp[i] = (b[i] ? a : 0) << i;
  - reduce them with 3:2 full-adder compressors (Wallace/Dadda style) to exactly two 16-bit rows, S and C.
- Edge k:
  - if in_valid=1, capture S, C into stage-1 registers and set v1=1;
  - otherwise set v1=0 and leave S/C don't-care. Clearing S/C is permitted but not required.
- Edge k+1:
  - if v1=1, y <= S + C (16-bit carry-propagate add) and out_valid <= 1;
  - if v1=0, out_valid <= 0 and y holds its previous value.
- Latency: exactly 2 rising edges from the sampled operands to y/out_valid.
- Throughput: 1 operation per cycle. Back-to-back in_valid pulses produce back-to-back results in order. No stalls, no backpressure.
- Width rule: the product never exceeds 16 bits (max 255*255 = 65025). Any carry beyond bit 15 in the S+C add is discarded and is provably zero for valid results.
- No signed mode, no saturation, no rounding.
- Operands: a/b are don't-care when in_valid=0. They must not affect y when in_valid=0.
- Reset mid-operation: in-flight operations are lost. y=0 and out_valid=0 until a new operation completes. The first valid result after rst deasserts appears 2 edges after the first in_valid sample.
- X-safety: with in_valid=0, out_valid must never go X after reset.

Test Plan:
- Reset: rst=1 for 3 cycles with random a/b and in_valid=1 -> y=0, out_valid=0 throughout; check both asynchronously, before any clock edge.
- Maximum: a=8'hFF, b=8'hFF, in_valid=1 for one cycle -> 2 edges later y=16'hFE01 (65025), out_valid=1 for exactly one cycle; y holds afterwards.
- Identity/zero: back-to-back (0,0x5A), (1,1), (0x80,0x02), (0xAA,0x55) -> y sequence 0x0000, 0x0001, 0x0100, 0x3872 on consecutive cycles, each with out_valid=1.
- Gaps: in_valid pattern 1,0,1 with (3,7) and (12,12) -> out_valid 1,0,1 with y=21 then 144; y unchanged during the gap cycle.
- Reset mid-flight: issue (0xFF,0x02), assert rst between the two pipeline edges -> no result emerges; y=0 and out_valid=0 until a fresh operation completes.
- Exhaustive: all 65536 (a,b) pairs streamed back-to-back -> every y equals a*b, in order, out_valid continuously 1.
